// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Round-robin arbiter with bounded burst hold in front of an
//               8N1 serializer driving the shared simulated UART line.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter  int NUM_REQ      = 4,
    parameter  int CLKS_PER_BIT = 16,
    parameter  int BURST        = 8,
    localparam int GW           = ($clog2(NUM_REQ) < 1) ? 1 : $clog2(NUM_REQ)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   uart_tx,
    output logic                   uart_tx_driven,
    output logic                   busy,
    output logic [GW-1:0]          grant_id
);

    localparam int              c_TW    = $clog2(CLKS_PER_BIT + 1);
    localparam logic [c_TW-1:0] c_LAST  = c_TW'(CLKS_PER_BIT - 1);
    localparam logic [7:0]      c_BURST = 8'(BURST);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [c_TW-1:0] r_timer;
    logic [2:0]      r_bit;
    logic [7:0]      r_shift;
    logic            r_tx;
    logic            r_driven;
    logic [GW-1:0]   r_grant;
    logic [7:0]      r_burst;

    logic            w_tick;
    logic            w_hold;
    logic            w_hi_found;
    logic            w_lo_found;
    logic [GW-1:0]   w_hi_idx;
    logic [GW-1:0]   w_lo_idx;
    logic            w_sel_valid;
    logic [GW-1:0]   w_sel_idx;
    logic [7:0]      w_sel_data;
    logic            w_hs;

    assign w_tick = (r_timer == c_LAST);

    // Requester selection: keep the current grantee while its burst lasts,
    // otherwise take the first valid requester after it (wrapping to itself).
    always_comb begin
        w_hi_found = 1'b0;
        w_lo_found = 1'b0;
        w_hi_idx   = '0;
        w_lo_idx   = '0;
        w_sel_data = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (req_valid[j]) begin
                if (GW'(j) > r_grant) begin
                    if (!w_hi_found) begin
                        w_hi_found = 1'b1;
                        w_hi_idx   = GW'(j);
                    end
                end else if (!w_lo_found) begin
                    w_lo_found = 1'b1;
                    w_lo_idx   = GW'(j);
                end
            end
        end
        w_hold      = (r_burst < c_BURST) && req_valid[r_grant];
        w_sel_valid = w_hold || w_hi_found || w_lo_found;
        if (w_hold) begin
            w_sel_idx = r_grant;
        end else if (w_hi_found) begin
            w_sel_idx = w_hi_idx;
        end else begin
            w_sel_idx = w_lo_idx;
        end
        for (int j = 0; j < NUM_REQ; j++) begin
            if (w_sel_idx == GW'(j)) begin
                w_sel_data = req_data[8*j +: 8];
            end
        end
    end

    // Ready is offered only to the selected requester while idle and out of reset.
    always_comb begin
        req_ready = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            req_ready[j] = (r_state == S_IDLE) && !reset && w_sel_valid &&
                           (w_sel_idx == GW'(j));
        end
    end

    assign w_hs = |(req_valid & req_ready);

    // Frame state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: each frame phase lasts CLKS_PER_BIT cycles per bit.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_hs) w_state_nxt = S_START;
            S_START: if (w_tick) w_state_nxt = S_DATA;
            S_DATA:  if (w_tick && (r_bit == 3'd7)) w_state_nxt = S_STOP;
            S_STOP:  if (w_tick) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath: byte capture, grant/burst bookkeeping, bit timing and line level.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_tx     <= 1'b1;
            r_driven <= 1'b0;
            r_grant  <= '0;
            r_burst  <= '0;
            r_timer  <= '0;
            r_bit    <= '0;
            r_shift  <= '0;
        end else begin
            r_driven <= 1'b1;
            if (r_state == S_IDLE) begin
                r_timer <= '0;
                r_bit   <= '0;
                r_tx    <= 1'b1;
                if (w_hs) begin
                    r_shift <= w_sel_data;
                    r_grant <= w_sel_idx;
                    r_burst <= w_hold ? (r_burst + 8'd1) : 8'd1;
                    r_tx    <= 1'b0;
                end else if (!w_sel_valid) begin
                    r_burst <= '0;
                end
            end else begin
                r_timer <= w_tick ? '0 : (r_timer + 1'b1);
                if (w_tick) begin
                    case (r_state)
                        S_START: r_tx <= r_shift[0];
                        S_DATA: begin
                            if (r_bit == 3'd7) begin
                                r_tx <= 1'b1;
                            end else begin
                                r_shift <= r_shift >> 1;
                                r_tx    <= r_shift[1];
                                r_bit   <= r_bit + 3'd1;
                            end
                        end
                        default: r_tx <= 1'b1;
                    endcase
                end
            end
        end
    end

    assign uart_tx        = r_tx;
    assign uart_tx_driven = r_driven;
    assign busy           = (r_state != S_IDLE);
    assign grant_id       = r_grant;

endmodule
`default_nettype wire

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter and 8N1 serializer that shares the single transmit line of the simulated UART between `NUM_REQ` independent byte-stream requesters. Requesters can be the boot ROM console, the test harness and core printf ports. Each requester presents bytes on a valid/ready handshake. The block grants one requester at a time, with bounded burst hold. It drives `uart_tx`/`uart_tx_driven` into the UART simulation model at `CLKS_PER_BIT` clocks per bit.

## Interface
- `NUM_REQ`, default 4: number of requesters; legal range 2..16.
- `CLKS_PER_BIT`, default 16: clocks per UART bit; legal range 2..65535.
- `BURST`, default 8: maximum consecutive bytes a requester keeps the grant; legal range 1..255.
- `GW` (localparam): max(1, clog2(`NUM_REQ`)).

- `clock` in 1: clock; all logic on posedge.
- `reset` in 1: reset, synchronous, active-high.
- `req_valid` in `NUM_REQ`: bit i high means requester i offers a byte.
- `req_data` in 8*`NUM_REQ`: byte of requester i in bits [8i+7:8i]; stable while valid.
- `req_ready` out `NUM_REQ`: one-hot or zero; a byte transfers on the cycle where `req_valid[i]` and `req_ready[i]` are both high.
- `uart_tx` out 1: serial line, idle high; registered.
- `uart_tx_driven` out 1: high once the line is under block control; registered.
- `busy` out 1: high while a frame is in flight (START/DATA/STOP).
- `grant_id` out `GW`: index of the current or most recent grantee.

## Operation
- State machine: IDLE, START, DATA, STOP.
  - IDLE → START on a handshake.
  - START → DATA after `CLKS_PER_BIT` cycles.
  - DATA → STOP after 8 bits.
  - STOP → IDLE after `CLKS_PER_BIT` cycles.
- `req_ready` is combinational. It is nonzero only in IDLE, when not in reset, and only for the selected requester.
- Selection in IDLE:
  - Burst hold: if burst count < `BURST` and `req_valid[grant_id]`, select `grant_id`.
  - Otherwise search from `grant_id+1` upward, wrapping modulo `NUM_REQ`, up to and including `grant_id`. Select the first requester with valid high.
  - No valid requester: no selection, burst count cleared to 0, stay in IDLE.
- Handshake:
  - `req_data` is captured into an 8-bit shift register.
  - `grant_id` is updated to the selected index.
  - Burst count becomes count+1 when the selection equals the previous `grant_id` under burst hold; otherwise it becomes 1.
- Frame bits:
  - START drives `uart_tx`=0.
  - DATA shifts bits out LSB first, bit 0 first.
  - STOP drives `uart_tx`=1.
- Bit timer: counts 0..`CLKS_PER_BIT`-1 and wraps; width is clog2(`CLKS_PER_BIT`+1). The bit index counts 0..7.
- A requester dropping valid after its handshake has no effect on the frame in flight.
- A sole active requester that has reached `BURST` is re-selected through the wrap-around search, and its count restarts at 1.

## Timing
- Reset values:
  - `uart_tx`=1, `uart_tx_driven`=0, `busy`=0, `grant_id`=0, `req_ready`=0.
  - State IDLE, burst count 0, timers 0.
- `uart_tx_driven` goes to 1 on the first clock edge with `reset` low and stays 1.
- Frame timing for a handshake in cycle t:
  - `uart_tx`=0 in cycles t+1..t+C, where C=`CLKS_PER_BIT`.
  - Data bit k in cycles t+1+C(k+1)..t+C(k+2).
  - Stop bit in cycles t+1+9C..t+10C.
  - IDLE again in cycle t+10C+1.
- Back-to-back bytes therefore have a period of exactly 10C+1 cycles.
- `busy`: high in cycles t+1..t+10C.
- `grant_id`: valid from cycle t+1.
- Minimum handshake latency: `req_ready` may rise in the same cycle `req_valid` rises, if the block is in IDLE. There is no internal bubble beyond the single IDLE cycle.
- Reset mid-frame:
  - The in-flight byte is dropped.
  - `uart_tx`=1 on the next edge.
  - No `req_ready` is asserted while `reset` is high.
  - The requester is not re-granted for the dropped byte; the byte is lost.

## Test plan
Bench parameters: `NUM_REQ`=4, `CLKS_PER_BIT`=4, `BURST`=2.
- Reset and idle: hold `reset` 3 cycles with all valids low.
  - Required: `uart_tx`=1 throughout; `uart_tx_driven` 0 during reset and 1 from the first edge after reset; `req_ready`=0; `busy`=0.
- Single byte: requester 2 sends 0xA5 at cycle t.
  - Required: handshake at t, `grant_id`=2.
  - `uart_tx` sequence 0,1,0,1,0,0,1,0,1,1, each level held 4 cycles, starting at t+1.
  - `busy` low at t+41.
- Round-robin with burst: all four requesters continuously valid, each sending a distinct byte.
  - Required grant order 0,0,1,1,2,2,3,3,0.
  - Consecutive handshakes exactly 41 cycles apart.
- Sole requester wrap: only requester 3 valid for 5 bytes.
  - Required: all 5 bytes granted to requester 3 with no gap beyond 41 cycles.
  - Burst count sequence 1,2,1,2,1.
- Drop-out: requester 1 granted one byte, deasserts valid; requester 0 then asserts.
  - Required: next grant goes to 0.
  - The frame in flight for requester 1 completes unchanged.
- Reset mid-frame: assert `reset` at data bit 3 of byte 0x3C.
  - Required: `uart_tx`=1 the next cycle; `busy`=0; `grant_id`=0.
  - A new byte after reset produces a complete, correct frame.
